// File: rtl/calc_pkg.sv
// Shared definitions for the calculator key-entry front end: key codes,
// entry state encoding and the default operand width.
package calc_pkg;

    localparam int OPERAND_W_DEF = 7;

    localparam logic [3:0] KEY_ADD = 4'd10;
    localparam logic [3:0] KEY_SUB = 4'd11;
    localparam logic [3:0] KEY_MUL = 4'd12;
    localparam logic [3:0] KEY_CLR = 4'd13;
    localparam logic [3:0] KEY_EQ  = 4'd14;
    localparam logic [3:0] KEY_BS  = 4'd15;

    typedef enum logic [1:0] {
        ST_OP1    = 2'd0,
        ST_OP2    = 2'd1,
        ST_RESULT = 2'd2
    } calc_state_e;

endpackage

// File: rtl/calc_key_entry_if.sv
// Keypad-event / calculator-bundle interface of calc_key_entry.
// master = keypad side, slave = key-entry block.
interface calc_key_entry_if #(
    parameter int OPERAND_W = calc_pkg::OPERAND_W_DEF
);
    logic                 key_valid;
    logic [3:0]           key_code;
    logic [OPERAND_W-1:0] in1;
    logic [OPERAND_W-1:0] in2;
    logic [3:0]           keyboard;
    logic                 modo;
    logic [1:0]           state;
    logic [1:0]           digit_cnt;

    modport master (
        output key_valid, key_code,
        input  in1, in2, keyboard, modo, state, digit_cnt
    );

    modport slave (
        input  key_valid, key_code,
        output in1, in2, keyboard, modo, state, digit_cnt
    );
endinterface

// File: rtl/calc_digit_acc.sv
// One decimal operand register plus its digit counter.
// CALC_BACKSPACE_EN adds the backspace (divide-by-ten) control.
module calc_digit_acc
    import calc_pkg::*;
#(
    parameter int MAX_DIGITS = 2,
    parameter int OPERAND_W  = OPERAND_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_clear,
    input  logic                 i_load,
    input  logic                 i_set,
`ifdef CALC_BACKSPACE_EN
    input  logic                 i_bs,
`endif
    input  logic [3:0]           i_digit,
    output logic [OPERAND_W-1:0] o_value,
    output logic [1:0]           o_cnt,
    output logic [1:0]           o_cnt_nxt
);

    localparam logic [1:0] MAX_CNT = 2'(MAX_DIGITS);

    logic [OPERAND_W+3:0] w_acc;
    logic [OPERAND_W-1:0] r_value;
    logic [OPERAND_W-1:0] w_value_nxt;
    logic [1:0]           r_cnt;
    logic [1:0]           w_cnt_nxt;

    assign w_acc = {4'b0000, r_value} * (OPERAND_W+4)'(4'd10)
                 + {{OPERAND_W{1'b0}}, i_digit};

    // Next operand/count: clear wins, then restart digit, then accumulate, then backspace
    always_comb begin
        w_value_nxt = r_value;
        w_cnt_nxt   = r_cnt;
        if (i_clear) begin
            w_value_nxt = '0;
            w_cnt_nxt   = 2'd0;
        end else if (i_set) begin
            w_value_nxt = {{(OPERAND_W-4){1'b0}}, i_digit};
            w_cnt_nxt   = 2'd1;
        end else if (i_load && (r_cnt < MAX_CNT)) begin
            w_value_nxt = w_acc[OPERAND_W-1:0];
            w_cnt_nxt   = r_cnt + 2'd1;
`ifdef CALC_BACKSPACE_EN
        end else if (i_bs && (r_cnt != 2'd0)) begin
            w_value_nxt = r_value / OPERAND_W'(4'd10);
            w_cnt_nxt   = r_cnt - 2'd1;
`endif
        end else begin
            w_value_nxt = r_value;
            w_cnt_nxt   = r_cnt;
        end
    end

    // Operand and digit-count registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= '0;
            r_cnt   <= 2'd0;
        end else begin
            r_value <= w_value_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign o_value   = r_value;
    assign o_cnt     = r_cnt;
    assign o_cnt_nxt = w_cnt_nxt;

endmodule

// File: rtl/calc_key_entry.sv
// Keypad-event to calculator operand/opcode/enable sequencer (OP1 -> OP2 -> RESULT).
// Optional macro CALC_BACKSPACE_EN enables key 15 as backspace.
module calc_key_entry
    import calc_pkg::*;
#(
    parameter int MAX_DIGITS = 2,
    parameter int OPERAND_W  = OPERAND_W_DEF
) (
    input logic             clk,
    input logic             rst_n,
    calc_key_entry_if.slave bus
);

    localparam logic [1:0] S_OP1    = ST_OP1;
    localparam logic [1:0] S_OP2    = ST_OP2;
    localparam logic [1:0] S_RESULT = ST_RESULT;

    logic [1:0]           r_state, w_state_nxt;
    logic [3:0]           r_keyboard, w_keyboard_nxt;
    logic                 r_modo, w_modo_nxt;
    logic [1:0]           r_digit_cnt;
    logic                 w_clear_all, w_clr1, w_clr2, w_load1, w_load2, w_set1;
`ifdef CALC_BACKSPACE_EN
    logic                 w_bs1, w_bs2;
`endif
    logic                 w_is_digit, w_is_op;
    logic [OPERAND_W-1:0] w_in1, w_in2;
    logic [1:0]           w_cnt1, w_cnt2, w_cnt1_nxt, w_cnt2_nxt;

    assign w_is_digit = (bus.key_code <= 4'd9);
    assign w_is_op    = (bus.key_code == KEY_ADD) || (bus.key_code == KEY_SUB) ||
                        (bus.key_code == KEY_MUL);

    // Key decode per entry state into operand controls and next state/opcode/modo
    always_comb begin
        w_state_nxt    = r_state;
        w_keyboard_nxt = r_keyboard;
        w_modo_nxt     = r_modo;
        w_clear_all    = 1'b0;
        w_clr1         = 1'b0;
        w_clr2         = 1'b0;
        w_load1        = 1'b0;
        w_load2        = 1'b0;
        w_set1         = 1'b0;
`ifdef CALC_BACKSPACE_EN
        w_bs1          = 1'b0;
        w_bs2          = 1'b0;
`endif
        case (r_state)
            S_OP1: begin
                if (!bus.key_valid) begin
                    w_state_nxt = r_state;
                end else if (w_is_digit) begin
                    w_load1 = 1'b1;
                end else if (w_is_op) begin
                    w_keyboard_nxt = bus.key_code;
                    w_state_nxt    = S_OP2;
                    w_clr2         = 1'b1;
                end else if (bus.key_code == KEY_CLR) begin
                    w_clear_all = 1'b1;
`ifdef CALC_BACKSPACE_EN
                end else if (bus.key_code == KEY_BS) begin
                    w_bs1 = 1'b1;
`endif
                end else begin
                    w_state_nxt = r_state;
                end
            end
            S_OP2: begin
                if (!bus.key_valid) begin
                    w_state_nxt = r_state;
                end else if (w_is_digit) begin
                    w_load2 = 1'b1;
                end else if (w_is_op) begin
                    // Operator may only be swapped before any second-operand digit
                    if (w_cnt2 == 2'd0) begin
                        w_keyboard_nxt = bus.key_code;
                    end else begin
                        w_keyboard_nxt = r_keyboard;
                    end
                end else if (bus.key_code == KEY_EQ) begin
                    w_modo_nxt  = 1'b1;
                    w_state_nxt = S_RESULT;
                end else if (bus.key_code == KEY_CLR) begin
                    w_clear_all = 1'b1;
`ifdef CALC_BACKSPACE_EN
                end else if (bus.key_code == KEY_BS) begin
                    if (w_cnt2 != 2'd0) begin
                        w_bs2 = 1'b1;
                    end else begin
                        w_keyboard_nxt = KEY_CLR;
                        w_state_nxt    = S_OP1;
                    end
`endif
                end else begin
                    w_state_nxt = r_state;
                end
            end
            S_RESULT: begin
                if (!bus.key_valid) begin
                    w_state_nxt = r_state;
                end else if (w_is_digit) begin
                    w_set1         = 1'b1;
                    w_clr2         = 1'b1;
                    w_keyboard_nxt = KEY_CLR;
                    w_modo_nxt     = 1'b0;
                    w_state_nxt    = S_OP1;
                end else if (bus.key_code == KEY_CLR) begin
                    w_clear_all = 1'b1;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            default: begin
                w_clear_all = 1'b1;
            end
        endcase
        if (w_clear_all) begin
            w_clr1         = 1'b1;
            w_clr2         = 1'b1;
            w_state_nxt    = S_OP1;
            w_keyboard_nxt = KEY_CLR;
            w_modo_nxt     = 1'b0;
        end else begin
            w_clr1 = 1'b0;
        end
    end

    calc_digit_acc #(.MAX_DIGITS(MAX_DIGITS), .OPERAND_W(OPERAND_W)) u_acc1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (w_clr1),
        .i_load    (w_load1),
        .i_set     (w_set1),
`ifdef CALC_BACKSPACE_EN
        .i_bs      (w_bs1),
`endif
        .i_digit   (bus.key_code),
        .o_value   (w_in1),
        .o_cnt     (w_cnt1),
        .o_cnt_nxt (w_cnt1_nxt)
    );

    calc_digit_acc #(.MAX_DIGITS(MAX_DIGITS), .OPERAND_W(OPERAND_W)) u_acc2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (w_clr2),
        .i_load    (w_load2),
        .i_set     (1'b0),
`ifdef CALC_BACKSPACE_EN
        .i_bs      (w_bs2),
`endif
        .i_digit   (bus.key_code),
        .o_value   (w_in2),
        .o_cnt     (w_cnt2),
        .o_cnt_nxt (w_cnt2_nxt)
    );

    // Entry state, opcode, enable and displayed digit-count registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_OP1;
            r_keyboard  <= KEY_CLR;
            r_modo      <= 1'b0;
            r_digit_cnt <= 2'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_keyboard  <= w_keyboard_nxt;
            r_modo      <= w_modo_nxt;
            r_digit_cnt <= (w_state_nxt == S_OP1) ? w_cnt1_nxt : w_cnt2_nxt;
        end
    end

    assign bus.in1       = w_in1;
    assign bus.in2       = w_in2;
    assign bus.keyboard  = r_keyboard;
    assign bus.modo      = r_modo;
    assign bus.state     = r_state;
    assign bus.digit_cnt = r_digit_cnt;

endmodule

// File: tb/tb_calc_key_entry.sv
// Directed, table-driven bench for calc_key_entry (default build or CALC_BACKSPACE_EN).
module tb_calc_key_entry;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    calc_key_entry_if #(.OPERAND_W(7)) bus ();

    calc_key_entry #(.MAX_DIGITS(2), .OPERAND_W(7)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       v;
        logic [3:0] code;
        logic [6:0] e1;
        logic [6:0] e2;
        logic [3:0] kb;
        logic       m;
        logic [1:0] st;
        logic [1:0] dc;
        logic       cdc;
    } vec_t;

    vec_t tab[$];

    task automatic addv(input logic v, input logic [3:0] code, input logic [6:0] e1,
                        input logic [6:0] e2, input logic [3:0] kb, input logic m,
                        input logic [1:0] st, input logic [1:0] dc, input logic cdc);
        vec_t t;
        t.v = v; t.code = code; t.e1 = e1; t.e2 = e2; t.kb = kb;
        t.m = m; t.st = st; t.dc = dc; t.cdc = cdc;
        tab.push_back(t);
    endtask

    task automatic check(input string name, input logic [6:0] e1, input logic [6:0] e2,
                         input logic [3:0] kb, input logic m, input logic [1:0] st,
                         input logic [1:0] dc, input logic cdc);
        checks++;
        if (bus.in1 !== e1 || bus.in2 !== e2 || bus.keyboard !== kb || bus.modo !== m ||
            bus.state !== st || (cdc && bus.digit_cnt !== dc)) begin
            failures++;
            $display("FAIL %s: got in1=%0d in2=%0d kb=%0d modo=%0d state=%0d dc=%0d, want in1=%0d in2=%0d kb=%0d modo=%0d state=%0d dc=%0d",
                     name, bus.in1, bus.in2, bus.keyboard, bus.modo, bus.state, bus.digit_cnt,
                     e1, e2, kb, m, st, dc);
        end
    endtask

    task automatic press(input logic v, input logic [3:0] code);
        @(negedge clk);
        bus.key_valid = v;
        bus.key_code  = code;
        @(posedge clk);
        #1;
        bus.key_valid = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        bus.key_valid = 1'b0;
        bus.key_code  = 4'd0;

        //      v     code   in1    in2    kb     m     st    dc    cdc
        addv(1'b1, 4'd4,  7'd4,  7'd0,  4'd13, 1'b0, 2'd0, 2'd1, 1'b1);
        addv(1'b1, 4'd2,  7'd42, 7'd0,  4'd13, 1'b0, 2'd0, 2'd2, 1'b1);
        addv(1'b1, 4'd10, 7'd42, 7'd0,  4'd10, 1'b0, 2'd1, 2'd0, 1'b1);
        addv(1'b1, 4'd1,  7'd42, 7'd1,  4'd10, 1'b0, 2'd1, 2'd1, 1'b1);
        addv(1'b1, 4'd7,  7'd42, 7'd17, 4'd10, 1'b0, 2'd1, 2'd2, 1'b1);
        addv(1'b1, 4'd14, 7'd42, 7'd17, 4'd10, 1'b1, 2'd2, 2'd0, 1'b0);
        addv(1'b0, 4'd3,  7'd42, 7'd17, 4'd10, 1'b1, 2'd2, 2'd0, 1'b0);
        addv(1'b1, 4'd11, 7'd42, 7'd17, 4'd10, 1'b1, 2'd2, 2'd0, 1'b0);
        addv(1'b1, 4'd14, 7'd42, 7'd17, 4'd10, 1'b1, 2'd2, 2'd0, 1'b0);
        addv(1'b1, 4'd15, 7'd42, 7'd17, 4'd10, 1'b1, 2'd2, 2'd0, 1'b0);
        addv(1'b1, 4'd8,  7'd8,  7'd0,  4'd13, 1'b0, 2'd0, 2'd1, 1'b1);
        addv(1'b1, 4'd13, 7'd0,  7'd0,  4'd13, 1'b0, 2'd0, 2'd0, 1'b1);
        addv(1'b1, 4'd1,  7'd1,  7'd0,  4'd13, 1'b0, 2'd0, 2'd1, 1'b1);
        addv(1'b1, 4'd2,  7'd12, 7'd0,  4'd13, 1'b0, 2'd0, 2'd2, 1'b1);
        addv(1'b1, 4'd3,  7'd12, 7'd0,  4'd13, 1'b0, 2'd0, 2'd2, 1'b1);
        addv(1'b1, 4'd11, 7'd12, 7'd0,  4'd11, 1'b0, 2'd1, 2'd0, 1'b1);
        addv(1'b1, 4'd9,  7'd12, 7'd9,  4'd11, 1'b0, 2'd1, 2'd1, 1'b1);
        addv(1'b1, 4'd9,  7'd12, 7'd99, 4'd11, 1'b0, 2'd1, 2'd2, 1'b1);
        addv(1'b1, 4'd9,  7'd12, 7'd99, 4'd11, 1'b0, 2'd1, 2'd2, 1'b1);
        addv(1'b1, 4'd14, 7'd12, 7'd99, 4'd11, 1'b1, 2'd2, 2'd0, 1'b0);
        addv(1'b1, 4'd13, 7'd0,  7'd0,  4'd13, 1'b0, 2'd0, 2'd0, 1'b1);
        addv(1'b1, 4'd5,  7'd5,  7'd0,  4'd13, 1'b0, 2'd0, 2'd1, 1'b1);
        addv(1'b1, 4'd11, 7'd5,  7'd0,  4'd11, 1'b0, 2'd1, 2'd0, 1'b1);
        addv(1'b1, 4'd12, 7'd5,  7'd0,  4'd12, 1'b0, 2'd1, 2'd0, 1'b1);
        addv(1'b1, 4'd3,  7'd5,  7'd3,  4'd12, 1'b0, 2'd1, 2'd1, 1'b1);
        addv(1'b1, 4'd10, 7'd5,  7'd3,  4'd12, 1'b0, 2'd1, 2'd1, 1'b1);
        addv(1'b1, 4'd14, 7'd5,  7'd3,  4'd12, 1'b1, 2'd2, 2'd0, 1'b0);
        addv(1'b1, 4'd13, 7'd0,  7'd0,  4'd13, 1'b0, 2'd0, 2'd0, 1'b1);
        addv(1'b1, 4'd6,  7'd6,  7'd0,  4'd13, 1'b0, 2'd0, 2'd1, 1'b1);
        addv(1'b1, 4'd10, 7'd6,  7'd0,  4'd10, 1'b0, 2'd1, 2'd0, 1'b1);
        addv(1'b1, 4'd2,  7'd6,  7'd2,  4'd10, 1'b0, 2'd1, 2'd1, 1'b1);
        addv(1'b1, 4'd13, 7'd0,  7'd0,  4'd13, 1'b0, 2'd0, 2'd0, 1'b1);
        addv(1'b1, 4'd14, 7'd0,  7'd0,  4'd13, 1'b0, 2'd0, 2'd0, 1'b1);
        addv(1'b1, 4'd10, 7'd0,  7'd0,  4'd10, 1'b0, 2'd1, 2'd0, 1'b1);
        addv(1'b1, 4'd14, 7'd0,  7'd0,  4'd10, 1'b1, 2'd2, 2'd0, 1'b0);
        addv(1'b1, 4'd13, 7'd0,  7'd0,  4'd13, 1'b0, 2'd0, 2'd0, 1'b1);
        addv(1'b1, 4'd0,  7'd0,  7'd0,  4'd13, 1'b0, 2'd0, 2'd1, 1'b1);
        addv(1'b1, 4'd9,  7'd9,  7'd0,  4'd13, 1'b0, 2'd0, 2'd2, 1'b1);
        addv(1'b1, 4'd5,  7'd9,  7'd0,  4'd13, 1'b0, 2'd0, 2'd2, 1'b1);
        addv(1'b1, 4'd13, 7'd0,  7'd0,  4'd13, 1'b0, 2'd0, 2'd0, 1'b1);
        addv(1'b1, 4'd4,  7'd4,  7'd0,  4'd13, 1'b0, 2'd0, 2'd1, 1'b1);
        addv(1'b1, 4'd2,  7'd42, 7'd0,  4'd13, 1'b0, 2'd0, 2'd2, 1'b1);
`ifdef CALC_BACKSPACE_EN
        addv(1'b1, 4'd15, 7'd4,  7'd0,  4'd13, 1'b0, 2'd0, 2'd1, 1'b1);
        addv(1'b1, 4'd10, 7'd4,  7'd0,  4'd10, 1'b0, 2'd1, 2'd0, 1'b1);
        addv(1'b1, 4'd7,  7'd4,  7'd7,  4'd10, 1'b0, 2'd1, 2'd1, 1'b1);
        addv(1'b1, 4'd15, 7'd4,  7'd0,  4'd10, 1'b0, 2'd1, 2'd0, 1'b1);
        addv(1'b1, 4'd15, 7'd4,  7'd0,  4'd13, 1'b0, 2'd0, 2'd1, 1'b1);
        addv(1'b1, 4'd15, 7'd0,  7'd0,  4'd13, 1'b0, 2'd0, 2'd0, 1'b1);
`else
        addv(1'b1, 4'd15, 7'd42, 7'd0,  4'd13, 1'b0, 2'd0, 2'd2, 1'b1);
        addv(1'b1, 4'd10, 7'd42, 7'd0,  4'd10, 1'b0, 2'd1, 2'd0, 1'b1);
        addv(1'b1, 4'd7,  7'd42, 7'd7,  4'd10, 1'b0, 2'd1, 2'd1, 1'b1);
        addv(1'b1, 4'd15, 7'd42, 7'd7,  4'd10, 1'b0, 2'd1, 2'd1, 1'b1);
`endif
        addv(1'b1, 4'd13, 7'd0,  7'd0,  4'd13, 1'b0, 2'd0, 2'd0, 1'b1);

        #12;
        check("reset_state", 7'd0, 7'd0, 4'd13, 1'b0, 2'd0, 2'd0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tab.size(); i++) begin
            press(tab[i].v, tab[i].code);
            check($sformatf("vec%0d", i), tab[i].e1, tab[i].e2, tab[i].kb, tab[i].m,
                  tab[i].st, tab[i].dc, tab[i].cdc);
        end

        // Key 7 held high for three cycles from an empty operand
        @(negedge clk);
        bus.key_valid = 1'b1;
        bus.key_code  = 4'd7;
        @(posedge clk); #1;
        check("hold_1", 7'd7, 7'd0, 4'd13, 1'b0, 2'd0, 2'd1, 1'b1);
        @(posedge clk); #1;
        check("hold_2", 7'd77, 7'd0, 4'd13, 1'b0, 2'd0, 2'd2, 1'b1);
        @(posedge clk); #1;
        bus.key_valid = 1'b0;
        check("hold_3", 7'd77, 7'd0, 4'd13, 1'b0, 2'd0, 2'd2, 1'b1);

        // Asynchronous reset mid-entry, then first key after release
        press(1'b1, 4'd10);
        press(1'b1, 4'd5);
        check("pre_reset", 7'd77, 7'd5, 4'd10, 1'b0, 2'd1, 2'd1, 1'b1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 7'd0, 7'd0, 4'd13, 1'b0, 2'd0, 2'd0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_release_idle", 7'd0, 7'd0, 4'd13, 1'b0, 2'd0, 2'd0, 1'b1);
        press(1'b1, 4'd3);
        check("post_release_key", 7'd3, 7'd0, 4'd13, 1'b0, 2'd0, 2'd1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
